nv_nvdla_sdp_hls_relu_grad: RTL
===============================

# nv_nvdla_sdp_hls_relu_grad

Backward (gradient) counterpart of the SDP HLS ReLU stage. The forward side pushes the pre-activation operands, and the block stores only their sign-derived keep bits in a mask FIFO. Gradient words then arrive in the same order and are masked against those bits: a gradient passes where the forward operand was non-negative and is zeroed otherwise. It sits beside the SDP ReLU path as a streaming element with valid/ready handshakes on all three ports.

## Interface
- DATA_WIDTH, 32: width of forward operand, gradient and output words (two's complement, MSB = sign)
- MASK_DEPTH, 16: mask FIFO entries; power of two, ≥2
- AW, log2(MASK_DEPTH): FIFO pointer width

- nvdla_core_clk  in  1  sole clock; all state on rising edge
- nvdla_core_rstn  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous flush of FIFO and output stage
- fwd_pvld  in  1  forward operand valid
- fwd_prdy  out  1  mask FIFO can accept
- fwd_data  in  DATA_WIDTH  forward (pre-ReLU) operand; only bit DATA_WIDTH-1 is used
- grad_pvld  in  1  gradient valid
- grad_prdy  out  1  gradient accepted this cycle when high with grad_pvld
- grad_data  in  DATA_WIDTH  incoming gradient
- out_pvld  out  1  masked gradient valid
- out_prdy  in  1  downstream ready
- out_data  out  DATA_WIDTH  masked gradient
- mask_count  out  AW+1  FIFO occupancy, 0..MASK_DEPTH

## Operation
- Forward push when fwd_pvld && fwd_prdy: write keep = ~fwd_data[DATA_WIDTH-1] at wr_ptr, then wr_ptr++. Pointers wrap modulo MASK_DEPTH.
- fwd_prdy = (mask_count != MASK_DEPTH). This depends on registered count only; there is no same-cycle pop credit.
- Gradient accept when grad_pvld && grad_prdy.
- grad_prdy = (mask_count != 0) && (!out_pvld || out_prdy).
- On accept: pop the mask at rd_ptr, then rd_ptr++. Load out_data = keep ? grad_data : 0 and set out_pvld = 1.
- Output hold: if out_pvld && !out_prdy, out_data and out_pvld stay stable.
- If out_prdy && out_pvld and there is no new accept, out_pvld clears next cycle and out_data holds its last value.
- No bypass: a mask written in cycle N is usable by a gradient no earlier than cycle N+1. With mask_count == 0, grad_prdy stays 0 even if fwd pushes in the same cycle.
- Simultaneous push and pop: mask_count unchanged, both pointers advance. Legal at any non-empty, non-full occupancy. At full, only pop occurs. At empty, only push occurs.
- Zero handling: fwd operand +0 (sign 0) gives keep = 1. Negative zero does not exist in two's complement. Gradient magnitude is never altered or saturated.
- clr (has priority over push and pop in the same cycle):
  - next cycle: mask_count = 0, pointers = 0, out_pvld = 0
  - out_data is not cleared
  - inputs presented during the clr cycle are dropped, even if the ready outputs read high.
- No state machine beyond the FIFO pointers and the single output register.

## Timing
- Reset values:
  - out_pvld = 0, out_data = 0, mask_count = 0, pointers = 0
  - hence fwd_prdy = 1 and grad_prdy = 0 while and after reset
  - FIFO storage is not reset.
- Latency: gradient accepted in cycle N gives out_pvld/out_data in cycle N+1.
- Throughput: 1 gradient/cycle sustained while masks are available and out_prdy = 1.
- fwd_prdy and grad_prdy are combinational from registered state and out_prdy. There is no combinational path from fwd_pvld or grad_pvld to any ready.
- Reset asserted mid-stream: everything returns to reset values immediately (asynchronous). In-flight masks and output are lost.

## Test plan
- Basic mask:
  - stimulus: push fwd 0x00000005, 0xFFFFFFFB, 0x00000000, 0x80000000, then grads 0x11, 0x22, 0x33, 0x44 with out_prdy = 1
  - required: out_data 0x11, 0, 0x33, 0 each one cycle after accept; mask_count returns to 0.
- Full/empty:
  - stimulus: push 16 masks with no gradients
  - required: fwd_prdy = 0 at mask_count = 16; a 17th push is refused and count stays 16. Then drain 16 gradients; grad_prdy = 0 at count 0.
- No bypass:
  - stimulus: with FIFO empty, assert fwd_pvld and grad_pvld in the same cycle
  - required: grad_prdy = 0 that cycle; gradient accepted the next cycle; out_pvld the cycle after.
- Backpressure:
  - stimulus: hold out_prdy = 0 for 5 cycles after the first output
  - required: out_data stable, grad_prdy = 0 for those cycles, no mask popped. On release, 1/cycle resumes.
- Concurrent push/pop and wrap:
  - stimulus: 40 cycles of simultaneous push and pop at occupancy 8 with a random sign pattern
  - required: outputs match the sign pattern in order across pointer wrap; mask_count constant at 8.
- clr and async reset:
  - stimulus: assert clr at occupancy 5 with out_pvld = 1 and fwd_pvld = 1
  - required: next cycle count = 0, out_pvld = 0, pushed mask dropped.
  - stimulus: pulse nvdla_core_rstn low mid-stream between edges
  - required: out_pvld drops immediately without waiting for a clock edge.

Source files
------------

// File: rtl/nv_nvdla_sdp_hls_relu_grad.sv
// ReLU backward step: the forward pass stores one keep bit per operand, and each
// gradient is passed or zeroed using the oldest stored bit, one word per cycle.
module nv_nvdla_sdp_hls_relu_grad #(
  parameter int DATA_WIDTH = 32,
  parameter int MASK_DEPTH = 16,
  parameter int AW         = $clog2(MASK_DEPTH)
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  clr,
  input  logic                  fwd_pvld,
  output logic                  fwd_prdy,
  input  logic [DATA_WIDTH-1:0] fwd_data,
  input  logic                  grad_pvld,
  output logic                  grad_prdy,
  input  logic [DATA_WIDTH-1:0] grad_data,
  output logic                  out_pvld,
  input  logic                  out_prdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [AW:0]           mask_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(MASK_DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  logic [MASK_DEPTH-1:0] mask_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           cnt_q, cnt_d;
  logic                  out_pvld_q, out_pvld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  push, pop;

  // Readies come only from registered state and out_prdy, never from the pvld inputs.
  assign fwd_prdy  = (cnt_q != FULL_CNT);
  assign grad_prdy = (cnt_q != '0) && (!out_pvld_q || out_prdy);

  // clr wins over any handshake that happens to complete in the same cycle.
  assign push = fwd_pvld  && fwd_prdy  && !clr;
  assign pop  = grad_pvld && grad_prdy && !clr;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    out_pvld_d = out_pvld_q;
    out_data_d = out_data_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      out_pvld_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ONE_PTR;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + ONE_CNT;
        2'b01:   cnt_d = cnt_q - ONE_CNT;
        default: cnt_d = cnt_q;
      endcase
      if (pop) begin
        out_pvld_d = 1'b1;
        out_data_d = mask_q[rd_ptr_q] ? grad_data : '0;
      end else if (out_prdy) begin
        out_pvld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      out_pvld_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      out_pvld_q <= out_pvld_d;
      out_data_q <= out_data_d;
    end
  end

  // Keep-bit storage carries no reset; the count guards every read.
  always_ff @(posedge nvdla_core_clk) begin
    if (push) mask_q[wr_ptr_q] <= ~fwd_data[DATA_WIDTH-1];
  end

  assign out_pvld   = out_pvld_q;
  assign out_data   = out_data_q;
  assign mask_count = cnt_q;

endmodule
